// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch stage feeding ctrlunit. Owns the PC and the
// instruction register, issues one-byte reads to a variable-latency
// instruction memory and times out to a NOP when no data comes back.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pc_clr              synchronous program restart (PC <= RESET_PC, clears error)
//   IR_EN               one-cycle fetch request
//   PCI, BRANCH         PC increment / PC load from br_target
//   br_target           branch address
//   im_addr, im_rd      instruction memory address and one-cycle read strobe
//   im_data, im_valid   instruction memory read data and its one-cycle valid
//   instr               instruction register contents
//   pc                  current PC
//   fetch_busy          read outstanding
//   fetch_err           sticky error (timeout or request while busy)
//   fetch_cnt           successful fetch count, only with FETCH_CNT_EN defined
//
// Optional feature: define FETCH_CNT_EN to add the saturating fetch_cnt port.
module ifetch_unit #(
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [7:0]        NOP_INSTR = 8'hF0,
  parameter int unsigned       MAX_WAIT  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_clr,
  input  logic              IR_EN,
  input  logic              PCI,
  input  logic              BRANCH,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] im_addr,
  output logic              im_rd,
  input  logic [7:0]        im_data,
  input  logic              im_valid,
  output logic [7:0]        instr,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_busy,
  output logic              fetch_err
`ifdef FETCH_CNT_EN
  ,
  output logic [15:0]       fetch_cnt
`endif
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        instr_q, instr_d;
  logic              im_rd_q, im_rd_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              accept_c;
  logic              timeout_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; im_valid outside WAIT is never accepted
  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (IR_EN) state_d = S_REQ;
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (im_valid) begin
          accept_c = 1'b1;
          state_d  = S_IDLE;
        end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
          timeout_c = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs
  always_comb begin
    pc_d    = pc_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    err_d   = err_q;

    // PC priority: pc_clr > BRANCH > PCI
    if (pc_clr)      pc_d = RESET_PC;
    else if (BRANCH) pc_d = br_target;
    else if (PCI)    pc_d = pc_q + ADDR_W'(1);

    // Fetch address is the PC before any same-cycle PC update
    if (state_q == S_IDLE && IR_EN) addr_d = pc_q;

    if (state_q == S_REQ) begin
      cnt_d = '0;
    end else if (state_q == S_WAIT && !accept_c && !timeout_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (accept_c)       instr_d = im_data;
    else if (timeout_c) instr_d = NOP_INSTR;

    // pc_clr wins over a same-cycle error source
    if (timeout_c || (IR_EN && busy_q)) err_d = 1'b1;
    if (pc_clr) err_d = 1'b0;

    // Registered versions of state-derived strobes
    im_rd_d = (state_d == S_REQ);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      cnt_q   <= '0;
      instr_q <= NOP_INSTR;
      im_rd_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      im_rd_q <= im_rd_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign pc         = pc_q;
  assign im_addr    = addr_q;
  assign im_rd      = im_rd_q;
  assign instr      = instr_q;
  assign fetch_busy = busy_q;
  assign fetch_err  = err_q;

`ifdef FETCH_CNT_EN
  logic [15:0] fcnt_q, fcnt_d;

  // Saturating count of accepted fetches; timeouts are not counted
  always_comb begin
    fcnt_d = fcnt_q;
    if (pc_clr) begin
      fcnt_d = '0;
    end else if (accept_c && fcnt_q != 16'hFFFF) begin
      fcnt_d = fcnt_q + 16'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  assign fetch_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: PC vector table, scoreboarded fetches
// against a variable-latency memory responder, and hand-written corner cases.
module tb_ifetch_unit;

  logic       clk;
  logic       rst_n;
  logic       pc_clr;
  logic       IR_EN;
  logic       PCI;
  logic       BRANCH;
  logic [7:0] br_target;
  logic [7:0] im_addr;
  logic       im_rd;
  logic [7:0] im_data;
  logic       im_valid;
  logic [7:0] instr;
  logic [7:0] pc;
  logic       fetch_busy;
  logic       fetch_err;
`ifdef FETCH_CNT_EN
  logic [15:0] fetch_cnt;
`endif

  ifetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_clr     (pc_clr),
    .IR_EN      (IR_EN),
    .PCI        (PCI),
    .BRANCH     (BRANCH),
    .br_target  (br_target),
    .im_addr    (im_addr),
    .im_rd      (im_rd),
    .im_data    (im_data),
    .im_valid   (im_valid),
    .instr      (instr),
    .pc         (pc),
    .fetch_busy (fetch_busy),
    .fetch_err  (fetch_err)
`ifdef FETCH_CNT_EN
    ,
    .fetch_cnt  (fetch_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk;
  int n_fail;
  int exp_cnt;
  logic [7:0] exp_addr_q[$];
  logic [7:0] exp_instr_q[$];
  logic prev_busy;
  int  resp_lat;
  logic resp_on;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: im_rd pops the expected address, busy falling pops the expected instr
  task automatic monitor();
    logic [7:0] e;
    if (!rst_n) begin
      prev_busy = 1'b0;
    end else begin
      if (im_rd) begin
        if (exp_addr_q.size() == 0) chk("unexpected_im_rd", 32'(im_rd), 32'd0);
        else begin
          e = exp_addr_q.pop_front();
          chk("im_addr", 32'(im_addr), 32'(e));
        end
      end
      if (prev_busy && !fetch_busy) begin
        if (exp_instr_q.size() == 0) chk("unexpected_completion", 32'd1, 32'd0);
        else begin
          e = exp_instr_q.pop_front();
          chk("instr", 32'(instr), 32'(e));
        end
      end
      prev_busy = fetch_busy;
    end
  endtask

  // One cycle: sample mid-cycle, then land 1 time unit after the next rising edge
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  // Memory model: data = addr ^ 8'h3F, returned resp_lat cycles after the im_rd cycle
  initial begin : responder
    logic [7:0] a;
    im_valid = 1'b0;
    im_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && im_rd && resp_on) begin
        a = im_addr;
        repeat (resp_lat) @(posedge clk);
        #1;
        im_valid = 1'b1;
        im_data  = a ^ 8'h3F;
        @(posedge clk);
        #1;
        im_valid = 1'b0;
        im_data  = 8'h00;
      end
    end
  end

  task automatic branch_to(input logic [7:0] a);
    BRANCH = 1'b1; br_target = a;
    tick();
    BRANCH = 1'b0;
  endtask

  task automatic clear_pc();
    pc_clr = 1'b1;
    exp_cnt = 0;
    tick();
    pc_clr = 1'b0;
  endtask

  // Complete fetch from expected address a; returns number of busy cycles
  task automatic do_fetch(input logic [7:0] a, input int lat, input logic on, output int n);
    resp_lat = lat;
    resp_on  = on;
    exp_addr_q.push_back(a);
    exp_instr_q.push_back(on ? (a ^ 8'h3F) : 8'hF0);
    if (on) exp_cnt++;
    IR_EN = 1'b1;
    tick();
    IR_EN = 1'b0;
    n = 0;
    while (fetch_busy && n < 40) begin
      n++;
      tick();
    end
    tick();
  endtask

  typedef struct {
    logic       clr;
    logic       br;
    logic       pci;
    logic [7:0] tgt;
    logic [7:0] exp_pc;
  } pc_vec_t;

  pc_vec_t vec [7];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : test
    int n;
    vec[0] = '{clr: 1'b0, br: 1'b1, pci: 1'b0, tgt: 8'hFF, exp_pc: 8'hFF};
    vec[1] = '{clr: 1'b0, br: 1'b0, pci: 1'b1, tgt: 8'h00, exp_pc: 8'h00};
    vec[2] = '{clr: 1'b0, br: 1'b1, pci: 1'b1, tgt: 8'h20, exp_pc: 8'h20};
    vec[3] = '{clr: 1'b0, br: 1'b0, pci: 1'b1, tgt: 8'h99, exp_pc: 8'h21};
    vec[4] = '{clr: 1'b1, br: 1'b1, pci: 1'b1, tgt: 8'h77, exp_pc: 8'h00};
    vec[5] = '{clr: 1'b0, br: 1'b0, pci: 1'b0, tgt: 8'h33, exp_pc: 8'h00};
    vec[6] = '{clr: 1'b0, br: 1'b1, pci: 1'b0, tgt: 8'h05, exp_pc: 8'h05};

    n_chk = 0; n_fail = 0; exp_cnt = 0;
    prev_busy = 1'b0; resp_lat = 1; resp_on = 1'b1;
    rst_n = 1'b0; pc_clr = 1'b0; IR_EN = 1'b0; PCI = 1'b0; BRANCH = 1'b0; br_target = 8'h00;

    // Reset values
    tick(); tick();
    chk("rst_pc", 32'(pc), 32'h00);
    chk("rst_instr", 32'(instr), 32'hF0);
    chk("rst_im_rd", 32'(im_rd), 32'd0);
    chk("rst_im_addr", 32'(im_addr), 32'h00);
    chk("rst_busy", 32'(fetch_busy), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // PC operations from the vector table
    for (int i = 0; i < 7; i++) begin
      pc_clr = vec[i].clr; BRANCH = vec[i].br; PCI = vec[i].pci; br_target = vec[i].tgt;
      tick();
      pc_clr = 1'b0; BRANCH = 1'b0; PCI = 1'b0;
      chk($sformatf("pc_vec%0d", i), 32'(pc), 32'(vec[i].exp_pc));
    end
    exp_cnt = 0;

    // Basic fetch at 8'h05, data two cycles after im_rd
    do_fetch(8'h05, 2, 1'b1, n);
    chk("fetch_busy_cycles", 32'(n), 32'd3);
    chk("fetch_err_clean", 32'(fetch_err), 32'd0);

    // Same-cycle IR_EN and PCI at 8'h10
    branch_to(8'h10);
    resp_lat = 1; resp_on = 1'b1;
    exp_addr_q.push_back(8'h10);
    exp_instr_q.push_back(8'h10 ^ 8'h3F);
    exp_cnt++;
    IR_EN = 1'b1; PCI = 1'b1;
    tick();
    IR_EN = 1'b0; PCI = 1'b0;
    chk("pc_after_pci_fetch", 32'(pc), 32'h11);
    n = 0;
    while (fetch_busy && n < 40) begin n++; tick(); end
    tick();
    chk("min_latency_busy", 32'(n), 32'd2);

    // Timeout with no response
    do_fetch(8'h11, 1, 1'b0, n);
    chk("timeout_busy_cycles", 32'(n), 32'd16);
    chk("timeout_err", 32'(fetch_err), 32'd1);
    clear_pc();
    chk("clr_err", 32'(fetch_err), 32'd0);
    chk("clr_pc", 32'(pc), 32'h00);

    // IR_EN during WAIT: dropped, error set, no second im_rd
    resp_lat = 4; resp_on = 1'b1;
    exp_addr_q.push_back(8'h00);
    exp_instr_q.push_back(8'h3F);
    exp_cnt++;
    IR_EN = 1'b1;
    tick();
    IR_EN = 1'b0;
    tick();
    IR_EN = 1'b1;
    tick();
    IR_EN = 1'b0;
    n = 2;
    while (fetch_busy && n < 40) begin n++; tick(); end
    tick();
    chk("busy_with_dropped_req", 32'(n), 32'd5);
    chk("dropped_req_err", 32'(fetch_err), 32'd1);

    // pc_clr during WAIT: fetch completes from latched address, error cleared
    branch_to(8'h40);
    resp_lat = 3; resp_on = 1'b1;
    exp_addr_q.push_back(8'h40);
    exp_instr_q.push_back(8'h40 ^ 8'h3F);
    IR_EN = 1'b1;
    tick();
    IR_EN = 1'b0;
    tick();
    pc_clr = 1'b1;
    exp_cnt = 0;
    tick();
    pc_clr = 1'b0;
    exp_cnt++;
    n = 0;
    while (fetch_busy && n < 40) begin n++; tick(); end
    tick();
    chk("clr_in_wait_err", 32'(fetch_err), 32'd0);
    chk("clr_in_wait_pc", 32'(pc), 32'h00);
`ifdef FETCH_CNT_EN
    chk("fetch_cnt_after_clr", 32'(fetch_cnt), 32'(exp_cnt));
`endif

    // Reset asserted mid-WAIT; the late im_valid must be ignored
    branch_to(8'h12);
    resp_lat = 3; resp_on = 1'b1;
    exp_addr_q.push_back(8'h12);
    IR_EN = 1'b1;
    tick();
    IR_EN = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    exp_cnt = 0;
    #1;
    chk("midrst_pc", 32'(pc), 32'h00);
    chk("midrst_instr", 32'(instr), 32'hF0);
    chk("midrst_im_rd", 32'(im_rd), 32'd0);
    chk("midrst_busy", 32'(fetch_busy), 32'd0);
    tick();
    rst_n = 1'b1;
    chk("late_valid_present", 32'(im_valid), 32'd1);
    tick();
    tick();
    chk("late_valid_instr", 32'(instr), 32'hF0);
    chk("late_valid_busy", 32'(fetch_busy), 32'd0);

    // Three good fetches and one timeout
    do_fetch(8'h00, 1, 1'b1, n);
    chk("cnt_seq_busy1", 32'(n), 32'd2);
    do_fetch(8'h00, 2, 1'b1, n);
    chk("cnt_seq_busy2", 32'(n), 32'd3);
    do_fetch(8'h00, 3, 1'b1, n);
    chk("cnt_seq_busy3", 32'(n), 32'd4);
    do_fetch(8'h00, 1, 1'b0, n);
    chk("cnt_seq_timeout", 32'(n), 32'd16);
`ifdef FETCH_CNT_EN
    chk("fetch_cnt_final", 32'(fetch_cnt), 32'(exp_cnt));
`endif

    tick();
    chk("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
    chk("instr_queue_drained", 32'(exp_instr_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
